// File: rtl/water_supply_arbiter_pkg.sv
// Shared types for the water-inlet arbiter: FSM state encoding and counter sizing helper.
package water_supply_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_FILL    = 2'd1,
    ARB_SUSPEND = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

  // One tick strobe equals one machine-timer time unit.
  localparam int TICKS_PER_UNIT = 1;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/water_supply_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after i_ptr, wrapping.
// Zero latency; o_vld low when no request is set.
module water_supply_arbiter_rr_picker
  import water_supply_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_vld
);

  int          w_sum;
  logic [IW-1:0] w_cand;

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_vld  = 1'b0;
    w_sum  = 0;
    w_cand = '0;
    for (int i = 1; i <= N; i++) begin
      w_sum = int'(i_ptr) + i;
      if (w_sum >= N) w_sum = w_sum - N;
      w_cand = IW'(w_sum);
      if (!o_vld && i_req[w_cand]) begin
        o_vld         = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/water_supply_arbiter.sv
// Shares one inlet valve among machines: round-robin grant, tick-based hold limit, supply suspend.
// Grant/valve appear one cycle after a sampled request; every grant is followed by a 2-cycle closed gap.
module water_supply_arbiter
  import water_supply_arbiter_pkg::*;
#(
  parameter int NUM_MACHINES   = 4,
  parameter int MAX_HOLD_TICKS = 60
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_tick,
  input  logic                    i_supply_ok,
  input  logic [NUM_MACHINES-1:0] i_fill_req,
  input  logic [NUM_MACHINES-1:0] i_fill_done,
  input  logic                    i_clr_err,
  output logic [NUM_MACHINES-1:0] o_fill_gnt,
  output logic                    o_valve_open,
  output logic [NUM_MACHINES-1:0] o_timeout_err,
  output logic                    o_busy
);

  localparam int IW = $clog2(NUM_MACHINES);
  localparam int HW = cnt_width(MAX_HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD_TICKS);

  arb_state_t              r_state, w_state_nxt;
  logic [NUM_MACHINES-1:0] r_gnt, w_gnt_nxt;
  logic [NUM_MACHINES-1:0] r_err, w_err_nxt;
  logic [HW-1:0]           r_hold, w_hold_nxt;
  logic [IW-1:0]           r_ptr, w_ptr_nxt;
  logic                    r_valve, w_valve_nxt;
  logic                    r_busy;

  logic [NUM_MACHINES-1:0] w_elig;
  logic [NUM_MACHINES-1:0] w_pick_gnt;
  logic [IW-1:0]           w_pick_idx;
  logic                    w_pick_vld;
  logic                    w_g_done;
  logic                    w_g_drop;
  logic [HW-1:0]           w_hold_inc;
  logic                    w_expire;

  assign w_elig = i_fill_req & ~r_err;

  water_supply_arbiter_rr_picker #(
    .N  (NUM_MACHINES),
    .IW (IW)
  ) u_picker (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_vld (w_pick_vld)
  );

  // Completion is judged only against the current grant, so stray done pulses are ignored.
  assign w_g_done   = |(i_fill_done & r_gnt);
  assign w_g_drop   = ~|(i_fill_req & r_gnt);
  assign w_hold_inc = r_hold + HW'(i_tick);
  assign w_expire   = i_tick && (w_hold_inc == HOLD_LIMIT);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_hold_nxt  = r_hold;
    w_ptr_nxt   = r_ptr;
    w_valve_nxt = 1'b0;
    w_err_nxt   = i_clr_err ? '0 : r_err;
    case (r_state)
      ARB_IDLE: begin
        w_gnt_nxt  = '0;
        w_hold_nxt = '0;
        if (w_pick_vld && i_supply_ok) begin
          w_state_nxt = ARB_FILL;
          w_gnt_nxt   = w_pick_gnt;
          w_ptr_nxt   = w_pick_idx;
          w_valve_nxt = 1'b1;
        end
      end
      ARB_FILL: begin
        w_hold_nxt  = w_hold_inc;
        w_valve_nxt = 1'b1;
        if (w_g_done || w_g_drop) begin
          w_state_nxt = ARB_RELEASE;
          w_gnt_nxt   = '0;
          w_valve_nxt = 1'b0;
        end else if (w_expire) begin
          // A fresh timeout survives a coincident clear.
          w_state_nxt = ARB_RELEASE;
          w_gnt_nxt   = '0;
          w_valve_nxt = 1'b0;
          w_err_nxt   = w_err_nxt | r_gnt;
        end else if (!i_supply_ok) begin
          w_state_nxt = ARB_SUSPEND;
          w_valve_nxt = 1'b0;
        end
      end
      ARB_SUSPEND: begin
        if (w_g_done || w_g_drop) begin
          w_state_nxt = ARB_RELEASE;
          w_gnt_nxt   = '0;
        end else if (i_supply_ok) begin
          w_state_nxt = ARB_FILL;
          w_valve_nxt = 1'b1;
        end
      end
      ARB_RELEASE: begin
        w_state_nxt = ARB_IDLE;
        w_gnt_nxt   = '0;
        w_hold_nxt  = '0;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_gnt_nxt   = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ARB_IDLE;
      r_gnt   <= '0;
      r_err   <= '0;
      r_hold  <= '0;
      r_ptr   <= IW'(NUM_MACHINES - 1);
      r_valve <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_err   <= w_err_nxt;
      r_hold  <= w_hold_nxt;
      r_ptr   <= w_ptr_nxt;
      r_valve <= w_valve_nxt;
      r_busy  <= (w_state_nxt != ARB_IDLE);
    end
  end

  assign o_fill_gnt    = r_gnt;
  assign o_valve_open  = r_valve;
  assign o_timeout_err = r_err;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_water_supply_arbiter.sv
// Scenario bench for water_supply_arbiter: expected grants queued at stimulus time, popped on grant.
module tb_water_supply_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 6;

  logic         clk;
  logic         rst_n;
  logic         tick;
  logic         supply_ok;
  logic         clr_err;
  logic [N-1:0] fill_req;
  logic [N-1:0] fill_done;
  logic [N-1:0] fill_gnt;
  logic         valve_open;
  logic [N-1:0] timeout_err;
  logic         busy;

  int           total;
  int           bad;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_g;

  water_supply_arbiter #(
    .NUM_MACHINES   (N),
    .MAX_HOLD_TICKS (MAXH)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_tick        (tick),
    .i_supply_ok   (supply_ok),
    .i_fill_req    (fill_req),
    .i_fill_done   (fill_done),
    .i_clr_err     (clr_err),
    .o_fill_gnt    (fill_gnt),
    .o_valve_open  (valve_open),
    .o_timeout_err (timeout_err),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (!$onehot0(fill_gnt) || (valve_open && fill_gnt == '0) || (valve_open && !busy)) begin
        bad++;
        $display("FAIL invariant: gnt=%b valve=%b busy=%b", fill_gnt, valve_open, busy);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    tick = 0; supply_ok = 0; clr_err = 0; fill_req = '0; fill_done = '0;
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    tick = 0; supply_ok = 1; clr_err = 0; fill_req = '0; fill_done = '0;
    rst_n = 1'b0;
    cyc();
    total++;
    if (fill_gnt !== 4'b0000 || valve_open !== 1'b0) begin
      bad++; $display("FAIL reset_gnt_valve: got gnt=%b valve=%b want 0000/0", fill_gnt, valve_open);
    end
    total++;
    if (timeout_err !== 4'b0000 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_err_busy: got err=%b busy=%b want 0000/0", timeout_err, busy);
    end
    rst_n = 1'b1;
    cyc();
    cyc();
    total++;
    if (busy !== 1'b0 || fill_gnt !== 4'b0000) begin
      bad++; $display("FAIL reset_idle_noreq: got busy=%b gnt=%b want 0/0000", busy, fill_gnt);
    end
  endtask

  task automatic test_single_fill();
    do_reset();
    supply_ok = 1; fill_req = 4'b0100;
    exp_q.push_back(4'b0100);
    cyc();
    exp_g = exp_q.pop_front();
    total++;
    if (fill_gnt !== exp_g || valve_open !== 1'b1) begin
      bad++; $display("FAIL single_grant: got gnt=%b valve=%b want %b/1", fill_gnt, valve_open, exp_g);
    end
    repeat (5) pulse_tick();
    total++;
    if (fill_gnt !== 4'b0100) begin
      bad++; $display("FAIL single_hold: got gnt=%b want 0100", fill_gnt);
    end
    fill_done = 4'b0100; fill_req = '0;
    cyc();
    fill_done = '0;
    total++;
    if (fill_gnt !== 4'b0000 || valve_open !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL single_release: got gnt=%b valve=%b busy=%b want 0000/0/1", fill_gnt, valve_open, busy);
    end
    cyc();
    total++;
    if (busy !== 1'b0 || timeout_err !== 4'b0000) begin
      bad++; $display("FAIL single_idle: got busy=%b err=%b want 0/0000", busy, timeout_err);
    end
  endtask

  task automatic test_round_robin();
    int zeros;
    do_reset();
    supply_ok = 1; fill_req = 4'b1111;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    for (int g = 0; g < 5; g++) begin
      zeros = (g == 0) ? 0 : 1;
      for (int k = 0; k < 20 && fill_gnt == '0; k++) begin
        cyc();
        if (fill_gnt == '0) zeros++;
      end
      exp_g = exp_q.pop_front();
      total++;
      if (fill_gnt !== exp_g) begin
        bad++; $display("FAIL rr_order[%0d]: got gnt=%b want %b", g, fill_gnt, exp_g);
      end
      if (g > 0) begin
        total++;
        if (zeros !== 2) begin
          bad++; $display("FAIL rr_gap[%0d]: got %0d idle cycles want 2", g, zeros);
        end
      end
      pulse_tick();
      pulse_tick();
      fill_done = fill_gnt;
      cyc();
      fill_done = '0;
      total++;
      if (fill_gnt !== 4'b0000 || valve_open !== 1'b0) begin
        bad++; $display("FAIL rr_release[%0d]: got gnt=%b valve=%b want 0000/0", g, fill_gnt, valve_open);
      end
    end
    fill_req = '0;
    cyc();
    cyc();
  endtask

  task automatic test_timeout();
    int seen;
    do_reset();
    supply_ok = 1; fill_req = 4'b0010;
    exp_q.push_back(4'b0010);
    cyc();
    exp_g = exp_q.pop_front();
    total++;
    if (fill_gnt !== exp_g) begin
      bad++; $display("FAIL to_grant: got gnt=%b want %b", fill_gnt, exp_g);
    end
    repeat (MAXH - 1) pulse_tick();
    total++;
    if (fill_gnt !== 4'b0010) begin
      bad++; $display("FAIL to_before_limit: got gnt=%b want 0010", fill_gnt);
    end
    tick = 1;
    cyc();
    tick = 0;
    total++;
    if (fill_gnt !== 4'b0000 || valve_open !== 1'b0 || timeout_err !== 4'b0010) begin
      bad++; $display("FAIL to_expire: got gnt=%b valve=%b err=%b want 0000/0/0010", fill_gnt, valve_open, timeout_err);
    end
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (fill_gnt != '0) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL to_masked: got %0d granted cycles want 0", seen);
    end
    fill_req = 4'b0110;
    exp_q.push_back(4'b0100);
    cyc();
    exp_g = exp_q.pop_front();
    total++;
    if (fill_gnt !== exp_g) begin
      bad++; $display("FAIL to_other_grant: got gnt=%b want %b", fill_gnt, exp_g);
    end
    repeat (MAXH - 1) pulse_tick();
    tick = 1; clr_err = 1;
    cyc();
    tick = 0; clr_err = 0;
    total++;
    if (timeout_err !== 4'b0100) begin
      bad++; $display("FAIL to_clr_collide: got err=%b want 0100", timeout_err);
    end
    exp_q.push_back(4'b0010);
    for (int k = 0; k < 10 && fill_gnt == '0; k++) cyc();
    exp_g = exp_q.pop_front();
    total++;
    if (fill_gnt !== exp_g) begin
      bad++; $display("FAIL to_regrant: got gnt=%b want %b", fill_gnt, exp_g);
    end
    fill_done = 4'b0010; fill_req = '0;
    cyc();
    fill_done = '0; clr_err = 1;
    cyc();
    clr_err = 0;
    total++;
    if (timeout_err !== 4'b0000) begin
      bad++; $display("FAIL to_clr: got err=%b want 0000", timeout_err);
    end
  endtask

  task automatic test_suspend();
    int errs;
    do_reset();
    supply_ok = 1; fill_req = 4'b0001;
    exp_q.push_back(4'b0001);
    cyc();
    exp_g = exp_q.pop_front();
    total++;
    if (fill_gnt !== exp_g) begin
      bad++; $display("FAIL sus_grant: got gnt=%b want %b", fill_gnt, exp_g);
    end
    pulse_tick();
    pulse_tick();
    supply_ok = 0;
    cyc();
    total++;
    if (valve_open !== 1'b0 || fill_gnt !== 4'b0001 || busy !== 1'b1) begin
      bad++; $display("FAIL sus_enter: got valve=%b gnt=%b busy=%b want 0/0001/1", valve_open, fill_gnt, busy);
    end
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      tick = (i % 3 == 0);
      cyc();
      if (valve_open !== 1'b0 || fill_gnt !== 4'b0001) errs++;
    end
    tick = 0;
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL sus_hold: got %0d bad cycles want 0", errs);
    end
    supply_ok = 1;
    cyc();
    total++;
    if (valve_open !== 1'b1 || fill_gnt !== 4'b0001) begin
      bad++; $display("FAIL sus_resume: got valve=%b gnt=%b want 1/0001", valve_open, fill_gnt);
    end
    repeat (3) pulse_tick();
    total++;
    if (fill_gnt !== 4'b0001 || timeout_err !== 4'b0000) begin
      bad++; $display("FAIL sus_frozen_cnt: got gnt=%b err=%b want 0001/0000", fill_gnt, timeout_err);
    end
    tick = 1;
    cyc();
    tick = 0;
    total++;
    if (fill_gnt !== 4'b0000 || timeout_err !== 4'b0001) begin
      bad++; $display("FAIL sus_limit: got gnt=%b err=%b want 0000/0001", fill_gnt, timeout_err);
    end
    fill_req = '0; clr_err = 1;
    cyc();
    clr_err = 0;
    cyc();
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    supply_ok = 1; fill_req = 4'b1001;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1000);
    cyc();
    exp_g = exp_q.pop_front();
    total++;
    if (fill_gnt !== exp_g) begin
      bad++; $display("FAIL rst_first: got gnt=%b want %b", fill_gnt, exp_g);
    end
    fill_done = 4'b0001;
    cyc();
    fill_done = '0;
    for (int k = 0; k < 10 && fill_gnt == '0; k++) cyc();
    exp_g = exp_q.pop_front();
    total++;
    if (fill_gnt !== exp_g) begin
      bad++; $display("FAIL rst_second: got gnt=%b want %b", fill_gnt, exp_g);
    end
    pulse_tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (fill_gnt !== 4'b0000 || valve_open !== 1'b0 || busy !== 1'b0 || timeout_err !== 4'b0000) begin
      bad++; $display("FAIL rst_async: got gnt=%b valve=%b busy=%b err=%b want all 0",
                      fill_gnt, valve_open, busy, timeout_err);
    end
    #1;
    rst_n = 1'b1;
    exp_q.push_back(4'b0001);
    cyc();
    exp_g = exp_q.pop_front();
    total++;
    if (fill_gnt !== exp_g) begin
      bad++; $display("FAIL rst_regrant: got gnt=%b want %b", fill_gnt, exp_g);
    end
    fill_req = '0;
    cyc();
    cyc();
  endtask

  task automatic test_done_at_limit();
    do_reset();
    supply_ok = 1; fill_req = 4'b0100;
    exp_q.push_back(4'b0100);
    cyc();
    exp_g = exp_q.pop_front();
    total++;
    if (fill_gnt !== exp_g) begin
      bad++; $display("FAIL dl_grant: got gnt=%b want %b", fill_gnt, exp_g);
    end
    fill_done = 4'b0001;
    cyc();
    fill_done = '0;
    total++;
    if (fill_gnt !== 4'b0100 || valve_open !== 1'b1) begin
      bad++; $display("FAIL dl_ignore_other_done: got gnt=%b valve=%b want 0100/1", fill_gnt, valve_open);
    end
    repeat (MAXH - 1) pulse_tick();
    tick = 1; fill_done = 4'b0100; fill_req = '0;
    cyc();
    tick = 0; fill_done = '0;
    total++;
    if (fill_gnt !== 4'b0000 || timeout_err !== 4'b0000) begin
      bad++; $display("FAIL dl_done_vs_limit: got gnt=%b err=%b want 0000/0000", fill_gnt, timeout_err);
    end
    cyc();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL dl_idle: got busy=%b want 0", busy);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_fill();
    test_round_robin();
    test_timeout();
    test_suspend();
    test_reset_mid_fill();
    test_done_at_limit();
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL sb_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
